rf_alu_sequencer: RTL and testbench

Multi-cycle controller for the register-file/ALU datapath (`RF_ALU`). Accepts one 32-bit command at a time over a valid/ready handshake. Decodes each command into the datapath's `RegSet`, `RegWrite`, `ALU_control`, `instr` and `Writedata` controls, and sequences register preload, ALU operations with writeback, and compare-only operations. Returns the ALU result and zero flag on a valid/ready response channel.

---
 rtl/rf_alu_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_rf_alu_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer: multi-cycle command sequencer for the RF_ALU register-file/ALU datapath.
// Define SEQ_RETIRE_CNT_EN to add the 16-bit retired-command counter port.
module rf_alu_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_instr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              RegSet,
    output logic              RegWrite,
    output logic [3:0]        ALU_control,
    output logic [31:0]       instr,
    output logic [DATA_W-1:0] Writedata,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic              Zero
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]       retired
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SET  = 3'd1,
        ST_EXEC = 3'd2,
        ST_WB   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        KIND_SET = 2'd0,
        KIND_ALU = 2'd1,
        KIND_CMP = 2'd2,
        KIND_ILL = 2'd3
    } kind_t;

    state_t      state_r;
    state_t      state_next_s;
    kind_t       kind_s;
    logic [3:0]  alu_ctl_s;
    logic        rd_nz_s;
    logic        accept_s;
    logic        cmd_ready_s;
    logic        wr_en_r;
    logic        reg_set_next_s;
    logic        reg_write_next_s;

    // Command decode straight off the input bus so the accept edge can latch everything at once.
    always_comb begin
        kind_s    = KIND_ILL;
        alu_ctl_s = 4'b0000;
        rd_nz_s   = (cmd_instr[11:7] != 5'd0);
        case (cmd_instr[6:0])
            7'b0000000: kind_s = KIND_SET;
            7'b0110011: begin
                case (cmd_instr[14:12])
                    3'b000: begin
                        if (cmd_instr[31:25] == 7'b0000000) begin
                            kind_s    = KIND_ALU;
                            alu_ctl_s = 4'b0010;
                        end else if (cmd_instr[31:25] == 7'b0100000) begin
                            kind_s    = KIND_ALU;
                            alu_ctl_s = 4'b0110;
                        end else begin
                            kind_s    = KIND_ILL;
                            alu_ctl_s = 4'b0000;
                        end
                    end
                    3'b111: begin
                        kind_s    = KIND_ALU;
                        alu_ctl_s = 4'b0000;
                    end
                    3'b110: begin
                        kind_s    = KIND_ALU;
                        alu_ctl_s = 4'b0001;
                    end
                    3'b010: begin
                        kind_s    = KIND_ALU;
                        alu_ctl_s = 4'b0111;
                    end
                    default: kind_s = KIND_ILL;
                endcase
            end
            7'b1100011: begin
                kind_s    = KIND_CMP;
                alu_ctl_s = 4'b0110;
            end
            default: kind_s = KIND_ILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (kind_s)
                        KIND_SET: state_next_s = ST_SET;
                        KIND_ALU: state_next_s = ST_EXEC;
                        KIND_CMP: state_next_s = ST_EXEC;
                        default:  state_next_s = ST_RESP;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SET:  state_next_s = ST_RESP;
            ST_EXEC: state_next_s = ST_WB;
            ST_WB:   state_next_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: ready flag and the next value of the registered write strobes.
    always_comb begin
        cmd_ready_s      = 1'b0;
        reg_set_next_s   = 1'b0;
        reg_write_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready_s    = 1'b1;
                reg_set_next_s = cmd_valid && (kind_s == KIND_SET) && rd_nz_s;
            end
            ST_EXEC: reg_write_next_s = wr_en_r;
            default: cmd_ready_s = 1'b0;
        endcase
    end

    assign cmd_ready = cmd_ready_s;
    assign accept_s  = cmd_valid && cmd_ready_s;

    // Registered datapath controls and response; strobes are one-cycle by construction of the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegSet      <= 1'b0;
            RegWrite    <= 1'b0;
            ALU_control <= 4'b0000;
            instr       <= 32'd0;
            Writedata   <= {DATA_W{1'b0}};
            rsp_valid   <= 1'b0;
            rsp_result  <= {DATA_W{1'b0}};
            rsp_zero    <= 1'b0;
            rsp_err     <= 1'b0;
            wr_en_r     <= 1'b0;
        end else begin
            RegSet    <= reg_set_next_s;
            RegWrite  <= reg_write_next_s;
            rsp_valid <= (state_next_s == ST_RESP);
            if (accept_s) begin
                rsp_err <= (kind_s == KIND_ILL);
                wr_en_r <= (kind_s == KIND_ALU) && rd_nz_s;
                case (kind_s)
                    KIND_SET: begin
                        instr     <= cmd_instr;
                        Writedata <= cmd_data;
                    end
                    KIND_ALU, KIND_CMP: begin
                        instr       <= cmd_instr;
                        ALU_control <= alu_ctl_s;
                    end
                    default: instr <= instr;
                endcase
            end
            if (state_r == ST_SET) begin
                rsp_result <= Writedata;
                rsp_zero   <= (Writedata == {DATA_W{1'b0}});
            end else if (state_r == ST_WB) begin
                rsp_result <= ALU_result;
                rsp_zero   <= Zero;
            end else begin
                rsp_result <= rsp_result;
            end
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    // Retired-command counter, one count per response handshake; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= 16'd0;
        end else if (rsp_valid && rsp_ready) begin
            retired <= retired + 16'd1;
        end else begin
            retired <= retired;
        end
    end
`endif

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Self-checking bench for rf_alu_sequencer: behavioural RF_ALU datapath plus an
// architectural register model predicting every response.
module tb_rf_alu_sequencer;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic          rsp_zero, rsp_err, RegSet, RegWrite, Zero;
    logic [31:0]   cmd_instr, instr;
    logic [DW-1:0] cmd_data, rsp_result, Writedata, ALU_result;
    logic [3:0]    ALU_control;
`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0]   retired;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] rf   [32];
    logic [31:0] mreg [32];
    logic [31:0] dp_a, dp_b;
    logic [31:0] exp_instr, exp_wd;
    logic [3:0]  exp_alu;
    int          exp_retired;

    always #5 clk = ~clk;

    rf_alu_sequencer #(.DATA_W(DW)) dut (
`ifdef SEQ_RETIRE_CNT_EN
        .retired(retired),
`endif
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .RegSet(RegSet), .RegWrite(RegWrite),
        .ALU_control(ALU_control), .instr(instr), .Writedata(Writedata),
        .ALU_result(ALU_result), .Zero(Zero)
    );

    // Behavioural RF_ALU datapath (x0 always reads zero).
    always_comb begin
        dp_a = (instr[19:15] == 5'd0) ? 32'd0 : rf[instr[19:15]];
        dp_b = (instr[24:20] == 5'd0) ? 32'd0 : rf[instr[24:20]];
        case (ALU_control)
            4'b0010: ALU_result = dp_a + dp_b;
            4'b0110: ALU_result = dp_a - dp_b;
            4'b0000: ALU_result = dp_a & dp_b;
            4'b0001: ALU_result = dp_a | dp_b;
            4'b0111: ALU_result = {31'd0, $signed(dp_a) < $signed(dp_b)};
            default: ALU_result = 32'd0;
        endcase
    end
    assign Zero = (ALU_result == 32'd0);

    always @(posedge clk) begin
        if (RegSet && instr[11:7] != 5'd0) rf[instr[11:7]] <= Writedata;
        else if (RegWrite && instr[11:7] != 5'd0) rf[instr[11:7]] <= ALU_result;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Architectural model: what each command should return and write.
    task automatic model(input logic [31:0] ins, input logic [31:0] dat,
                         output int lat, output int nset, output int nwr,
                         output bit ill, output logic [31:0] res, output bit z);
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b;
        rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
        a = mreg[ins[19:15]]; b = mreg[ins[24:20]];
        ill = 1'b0; nset = 0; nwr = 0; lat = 2; res = 32'd0;
        if (ins[6:0] == 7'b0000000) begin
            lat = 1; res = dat; nset = (rd != 5'd0) ? 1 : 0;
            if (rd != 5'd0) mreg[rd] = dat;
            exp_instr = ins; exp_wd = dat;
        end else if (ins[6:0] == 7'b0110011) begin
            if (f3 == 3'b000 && f7 == 7'b0000000) begin res = a + b; exp_alu = 4'b0010; end
            else if (f3 == 3'b000 && f7 == 7'b0100000) begin res = a - b; exp_alu = 4'b0110; end
            else if (f3 == 3'b111) begin res = a & b; exp_alu = 4'b0000; end
            else if (f3 == 3'b110) begin res = a | b; exp_alu = 4'b0001; end
            else if (f3 == 3'b010) begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; exp_alu = 4'b0111; end
            else ill = 1'b1;
            if (!ill) begin
                nwr = (rd != 5'd0) ? 1 : 0;
                if (rd != 5'd0) mreg[rd] = res;
                exp_instr = ins;
            end
        end else if (ins[6:0] == 7'b1100011) begin
            res = a - b; exp_alu = 4'b0110; exp_instr = ins;
        end else begin
            ill = 1'b1;
        end
        if (ill) lat = 0;
        z = (res == 32'd0);
    endtask

    // Runs one command starting from a falling edge in IDLE; ends on a falling edge in IDLE.
    task automatic do_cmd(input logic [31:0] ins, input logic [31:0] dat,
                          input int hold, input bit tied, input bit keep_valid);
        int lat, nset, nwr, waits, seen, cset, cwr;
        bit ill, z;
        logic [31:0] res;
        model(ins, dat, lat, nset, nwr, ill, res, z);
        rsp_ready = tied; cmd_valid = 1'b1; cmd_instr = ins; cmd_data = dat;
        waits = 0;
        while (!cmd_ready && waits < 20) begin @(negedge clk); waits++; end
        check("accept_wait", 32'(waits), 32'd0);
        @(posedge clk); #1;
        cmd_valid = keep_valid;
        @(negedge clk);
        seen = 0; cset = 0; cwr = 0;
        while (!rsp_valid && seen < 10) begin
            if (RegSet) begin
                cset++;
                check("set_instr", instr, ins);
                check("set_wdata", Writedata, dat);
            end
            if (RegWrite) begin cwr++; check("wb_alu_ctl", 32'(ALU_control), 32'(exp_alu)); end
            if (keep_valid) check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk); seen++;
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("latency", 32'(seen), 32'(lat));
        check("regset_cycles", 32'(cset), 32'(nset));
        check("regwrite_cycles", 32'(cwr), 32'(nwr));
        check("rsp_err", 32'(rsp_err), 32'(ill));
        if (!ill) begin
            check("rsp_result", rsp_result, res);
            check("rsp_zero", 32'(rsp_zero), 32'(z));
        end
        check("held_instr", instr, exp_instr);
        check("held_alu_ctl", 32'(ALU_control), 32'(exp_alu));
        check("held_wdata", Writedata, exp_wd);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_err", 32'(rsp_err), 32'(ill));
            if (!ill) check("hold_result", rsp_result, res);
            check("hold_strobes", 32'({RegSet, RegWrite}), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; rsp_ready = tied;
        exp_retired++;
        @(negedge clk);
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef SEQ_RETIRE_CNT_EN
        check("retired", 32'(retired), 32'(exp_retired & 16'hFFFF));
`endif
    endtask

    function automatic logic [31:0] gen_cmd(output logic [31:0] dat);
        int k, op;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7, opc;
        k = int'($urandom_range(0, 9));
        rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
        dat = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        f3 = 3'b000; f7 = 7'b0000000; opc = 7'b0110011;
        if (k <= 1) begin
            opc = 7'b0000000; rs1 = 5'd0; rs2 = 5'd0;
        end else if (k <= 6) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0: begin f3 = 3'b000; f7 = 7'b0000000; end
                1: begin f3 = 3'b000; f7 = 7'b0100000; end
                2: f3 = 3'b111;
                3: f3 = 3'b110;
                default: f3 = 3'b010;
            endcase
        end else if (k == 7) begin
            opc = 7'b1100011;
            if ($urandom_range(0, 1) == 0) rs2 = rs1;
        end else if (k == 8) begin
            case ($urandom_range(0, 3))
                0: opc = 7'h13;
                1: opc = 7'h03;
                2: opc = 7'h23;
                default: opc = 7'h6F;
            endcase
        end else begin
            if ($urandom_range(0, 1) == 0) f7 = 7'b0000001;
            else f3 = 3'(1 + 2 * $urandom_range(0, 1) + $urandom_range(0, 1) * 3);
        end
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    initial begin
        logic [31:0] ins, dat;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        exp_instr = 32'd0; exp_wd = 32'd0; exp_alu = 4'b0000; exp_retired = 0;
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_instr = 32'd0; cmd_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp", {rsp_result[29:0], rsp_valid, rsp_zero}, 32'd0);
        check("rst_err_strobes", 32'({rsp_err, RegSet, RegWrite}), 32'd0);
        check("rst_ctl", {instr[27:0], ALU_control}, 32'd0);
        check("rst_wdata", Writedata, 32'd0);
`ifdef SEQ_RETIRE_CNT_EN
        check("rst_retired", 32'(retired), 32'd0);
`endif
        reset = 1'b0;

        do_cmd(32'h00000080, 32'h0003EEEE, 0, 1'b0, 1'b0);
        do_cmd(32'h00000100, 32'h00001111, 0, 1'b1, 1'b0);
        do_cmd(32'h00208033, 32'h0, 0, 1'b1, 1'b0);
        do_cmd(32'h002081B3, 32'h0, 5, 1'b0, 1'b1);
        do_cmd(32'h00108063, 32'h0, 0, 1'b0, 1'b0);
        do_cmd(32'h00000013, 32'h0, 2, 1'b0, 1'b0);
        do_cmd(32'h022081B3, 32'h0, 0, 1'b1, 1'b0);

        // Reset while the add into x3 sits in its writeback cycle.
        cmd_valid = 1'b1; cmd_instr = 32'h002081B3; cmd_data = 32'd0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wb_before_reset", 32'(RegWrite), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstwb_strobes", 32'({RegSet, RegWrite, rsp_valid, rsp_err, rsp_zero}), 32'd0);
        check("rstwb_result", rsp_result, 32'd0);
        check("rstwb_ctl", {instr[27:0], ALU_control}, 32'd0);
        check("rstwb_wdata", Writedata, 32'd0);
        check("rstwb_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef SEQ_RETIRE_CNT_EN
        check("rstwb_retired", 32'(retired), 32'd0);
`endif
        reset = 1'b0;
        exp_instr = 32'd0; exp_wd = 32'd0; exp_alu = 4'b0000; exp_retired = 0;

        do_cmd(32'h00000180, 32'h00000005, 0, 1'b0, 1'b0);
        do_cmd(32'h00000200, 32'hFFFFFFFB, 1, 1'b0, 1'b0);
        do_cmd({7'd0, 5'd4, 5'd3, 3'b000, 5'd5, 7'b0110011}, 32'h0, 0, 1'b0, 1'b0);
`ifdef SEQ_RETIRE_CNT_EN
        check("retired_three", 32'(retired), 32'd3);
`endif

        for (int r = 1; r < 8; r++) do_cmd({20'd0, 5'(r), 7'd0}, $urandom, 0, 1'b1, 1'b0);
        for (int n = 0; n < 40; n++) begin
            bit tied;
            ins = gen_cmd(dat);
            tied = 1'($urandom_range(0, 1));
            do_cmd(ins, dat, tied ? 0 : int'($urandom_range(0, 3)), tied, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
